ibexc_data_arb: RTL and testbench

Two-requester arbiter that shares the core data memory port (OBI-style req/gnt/rvalid, 33-bit tagged data) between the CHERIoT core load/store unit and a secondary bus master (debug/DMA). It sits between `u_ibex_top` data signals and the system data bus. It does three things: round-robin arbitration, keeping both beats of a capability access together, and routing in-order responses back to their owner through an outstanding-transaction FIFO.

---
 rtl/ibexc_data_arb.sv | 152 +++++++++++++++
 tb/tb_ibexc_data_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ibexc_data_arb.sv
// Two-requester OBI data-port arbiter: round-robin core/secondary selection, capability
// beat locking, and in-order response routing through an owner-ID FIFO.
module ibexc_data_arb #(
    parameter int unsigned DataWidth      = 33,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 c_req_i,
    input  logic                 s_req_i,
    output logic                 c_gnt_o,
    output logic                 s_gnt_o,
    output logic                 c_rvalid_o,
    output logic                 s_rvalid_o,
    input  logic                 c_we_i,
    input  logic                 s_we_i,
    input  logic [3:0]           c_be_i,
    input  logic [3:0]           s_be_i,
    input  logic [31:0]          c_addr_i,
    input  logic [31:0]          s_addr_i,
    input  logic [DataWidth-1:0] c_wdata_i,
    input  logic [DataWidth-1:0] s_wdata_i,
    input  logic                 c_is_cap_i,
    input  logic                 s_is_cap_i,
    output logic [DataWidth-1:0] c_rdata_o,
    output logic [DataWidth-1:0] s_rdata_o,
    output logic                 c_err_o,
    output logic                 s_err_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [31:0]          data_addr_o,
    output logic [DataWidth-1:0] data_wdata_o,
    output logic                 data_is_cap_o,
    input  logic                 data_rvalid_i,
    input  logic [DataWidth-1:0] data_rdata_i,
    input  logic                 data_err_i,
    output logic                 unexp_rsp_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_LOCK} state_t;

    state_t          r_state;
    logic            r_owner;
    logic            r_rr_last;
    logic            r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    logic w_full, w_empty, w_arb_sel, w_sel, w_sel_req, w_sel_cap;
    logic w_push, w_pop, w_head;

    assign w_full  = (r_count == CntMax);
    assign w_empty = (r_count == '0);

    // On a tie the requester that did not win last time gets the bus.
    assign w_arb_sel = (c_req_i & s_req_i) ? ~r_rr_last : s_req_i;
    assign w_sel     = (r_state == ST_ARB) ? w_arb_sel : r_owner;
    assign w_sel_req = w_sel ? s_req_i    : c_req_i;
    assign w_sel_cap = w_sel ? s_is_cap_i : c_is_cap_i;

    assign data_req_o    = ~rst_i & ~w_full & w_sel_req;
    assign data_we_o     = data_req_o & (w_sel ? s_we_i : c_we_i);
    assign data_be_o     = {4{data_req_o}} & (w_sel ? s_be_i : c_be_i);
    assign data_addr_o   = {32{data_req_o}} & (w_sel ? s_addr_i : c_addr_i);
    assign data_wdata_o  = {DataWidth{data_req_o}} & (w_sel ? s_wdata_i : c_wdata_i);
    assign data_is_cap_o = data_req_o & w_sel_cap;

    assign w_push  = data_req_o & data_gnt_i;
    assign c_gnt_o = w_push & ~w_sel;
    assign s_gnt_o = w_push & w_sel;

    assign w_pop       = ~rst_i & data_rvalid_i & ~w_empty;
    assign w_head      = r_fifo[r_rptr];
    assign c_rvalid_o  = w_pop & ~w_head;
    assign s_rvalid_o  = w_pop & w_head;
    assign unexp_rsp_o = ~rst_i & data_rvalid_i & w_empty;

    assign c_rdata_o = data_rdata_i;
    assign s_rdata_o = data_rdata_i;
    assign c_err_o   = data_err_i;
    assign s_err_o   = data_err_i;

    // A full FIFO freezes the FSM; data_req_o is already low so nothing can be granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_ARB;
            r_owner   <= 1'b0;
            r_rr_last <= 1'b1;
        end else if (!w_full) begin
            case (r_state)
                ST_ARB: begin
                    if (data_req_o) begin
                        r_owner <= w_sel;
                        if (data_gnt_i) begin
                            if (w_sel_cap) r_state <= ST_LOCK;
                            else           r_rr_last <= w_sel;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!w_sel_req) begin
                        r_state <= ST_ARB;
                    end else if (data_gnt_i) begin
                        r_rr_last <= r_owner;
                        r_state   <= w_sel_cap ? ST_LOCK : ST_ARB;
                    end
                end
                ST_LOCK: begin
                    if (w_push) begin
                        r_rr_last <= r_owner;
                        r_state   <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MaxOutstanding; gi++) begin : g_fifo
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    r_fifo[gi] <= 1'b0;
                else if (w_push && (r_wptr == PtrW'(gi)))
                    r_fifo[gi] <= w_sel;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_ibexc_data_arb.sv
// Directed bench for ibexc_data_arb: a per-cycle vector table followed by a short
// hand-written sequence covering field muxing, cap locking and response broadcast.
module tb_ibexc_data_arb;
    localparam int DW = 33;

    logic          clk_i, rst_i;
    logic          c_req_i, s_req_i, c_gnt_o, s_gnt_o, c_rvalid_o, s_rvalid_o;
    logic          c_we_i, s_we_i;
    logic [3:0]    c_be_i, s_be_i;
    logic [31:0]   c_addr_i, s_addr_i;
    logic [DW-1:0] c_wdata_i, s_wdata_i;
    logic          c_is_cap_i, s_is_cap_i;
    logic [DW-1:0] c_rdata_o, s_rdata_o;
    logic          c_err_o, s_err_o;
    logic          data_req_o, data_gnt_i, data_we_o;
    logic [3:0]    data_be_o;
    logic [31:0]   data_addr_o;
    logic [DW-1:0] data_wdata_o;
    logic          data_is_cap_o, data_rvalid_i, data_err_i, unexp_rsp_o;
    logic [DW-1:0] data_rdata_i;

    ibexc_data_arb #(.DataWidth(DW), .MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_req_i(c_req_i), .s_req_i(s_req_i),
        .c_gnt_o(c_gnt_o), .s_gnt_o(s_gnt_o),
        .c_rvalid_o(c_rvalid_o), .s_rvalid_o(s_rvalid_o),
        .c_we_i(c_we_i), .s_we_i(s_we_i),
        .c_be_i(c_be_i), .s_be_i(s_be_i),
        .c_addr_i(c_addr_i), .s_addr_i(s_addr_i),
        .c_wdata_i(c_wdata_i), .s_wdata_i(s_wdata_i),
        .c_is_cap_i(c_is_cap_i), .s_is_cap_i(s_is_cap_i),
        .c_rdata_o(c_rdata_o), .s_rdata_o(s_rdata_o),
        .c_err_o(c_err_o), .s_err_o(s_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_is_cap_o(data_is_cap_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_err_i(data_err_i), .unexp_rsp_o(unexp_rsp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // in = {rst, c_req, s_req, c_cap, s_cap, gnt, rvalid}
    // exp = {data_req, c_gnt, s_gnt, c_rvalid, s_rvalid, unexp}
    typedef struct {
        logic [6:0]  in;
        logic [31:0] ca;
        logic [5:0]  exp;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [6:0] in, input logic [31:0] ca,
                                input logic [5:0] exp, input logic [31:0] eaddr);
        vec_t v;
        v.in = in; v.ca = ca; v.exp = exp; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        c_req_i = 0; s_req_i = 0; c_is_cap_i = 0; s_is_cap_i = 0;
        c_we_i = 1'b0; c_be_i = 4'hF; c_addr_i = 32'h100; c_wdata_i = 33'h0_0000_00C0;
        s_we_i = 1'b1; s_be_i = 4'h3; s_addr_i = 32'h200; s_wdata_i = 33'h1_2345_6789;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0; data_err_i = 0;

        tbl.push_back(mk(7'b1000000, 32'h100, 6'b000000, 32'h0));   // reset
        tbl.push_back(mk(7'b1110010, 32'h100, 6'b000000, 32'h0));   // reset masks requests
        tbl.push_back(mk(7'b0100010, 32'h100, 6'b110000, 32'h100)); // core-only stream
        tbl.push_back(mk(7'b0100011, 32'h104, 6'b110100, 32'h104));
        tbl.push_back(mk(7'b0100011, 32'h108, 6'b110100, 32'h108));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000100, 32'h0));
        tbl.push_back(mk(7'b1000000, 32'h100, 6'b000000, 32'h0));   // reset, then tie stream
        tbl.push_back(mk(7'b0110010, 32'h100, 6'b110000, 32'h100));
        tbl.push_back(mk(7'b0110011, 32'h100, 6'b101100, 32'h200));
        tbl.push_back(mk(7'b0110011, 32'h100, 6'b110010, 32'h100));
        tbl.push_back(mk(7'b0110011, 32'h100, 6'b101100, 32'h200));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000010, 32'h0));
        tbl.push_back(mk(7'b0010000, 32'h100, 6'b100000, 32'h200)); // sec held without gnt
        tbl.push_back(mk(7'b0110000, 32'h100, 6'b100000, 32'h200));
        tbl.push_back(mk(7'b0110000, 32'h100, 6'b100000, 32'h200));
        tbl.push_back(mk(7'b0110010, 32'h100, 6'b101000, 32'h200));
        tbl.push_back(mk(7'b0110011, 32'h100, 6'b110010, 32'h100));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000100, 32'h0));
        tbl.push_back(mk(7'b0101010, 32'h300, 6'b110000, 32'h300)); // core cap, two beats
        tbl.push_back(mk(7'b0111011, 32'h304, 6'b110100, 32'h304));
        tbl.push_back(mk(7'b0010011, 32'h100, 6'b101100, 32'h200));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000010, 32'h0));
        tbl.push_back(mk(7'b0100010, 32'h100, 6'b110000, 32'h100)); // fill FIFO
        tbl.push_back(mk(7'b0100010, 32'h100, 6'b110000, 32'h100));
        tbl.push_back(mk(7'b0100010, 32'h100, 6'b000000, 32'h0));
        tbl.push_back(mk(7'b0100011, 32'h100, 6'b000100, 32'h0));
        tbl.push_back(mk(7'b0100011, 32'h100, 6'b110100, 32'h100));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000100, 32'h0));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000001, 32'h0));   // unexpected response
        tbl.push_back(mk(7'b0000000, 32'h100, 6'b000000, 32'h0));
        tbl.push_back(mk(7'b0101010, 32'h100, 6'b110000, 32'h100)); // enter LOCK
        tbl.push_back(mk(7'b1111010, 32'h100, 6'b000000, 32'h0));   // reset in LOCK
        tbl.push_back(mk(7'b0110011, 32'h100, 6'b110001, 32'h100));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000100, 32'h0));
        tbl.push_back(mk(7'b0010000, 32'h100, 6'b100000, 32'h200)); // HOLD then owner drops
        tbl.push_back(mk(7'b0100010, 32'h100, 6'b000000, 32'h0));
        tbl.push_back(mk(7'b0100010, 32'h100, 6'b110000, 32'h100));
        tbl.push_back(mk(7'b0000001, 32'h100, 6'b000100, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            {rst_i, c_req_i, s_req_i, c_is_cap_i, s_is_cap_i, data_gnt_i, data_rvalid_i} = tbl[i].in;
            c_addr_i = tbl[i].ca;
            #1;
            chk($sformatf("vec%0d ctrl", i),
                64'({data_req_o, c_gnt_o, s_gnt_o, c_rvalid_o, s_rvalid_o, unexp_rsp_o}),
                64'(tbl[i].exp));
            chk($sformatf("vec%0d addr", i), 64'(data_addr_o), 64'(tbl[i].eaddr));
            $display("vec%0d in=%b addr=%0h ctrl=%b", i, tbl[i].in, data_addr_o,
                     {data_req_o, c_gnt_o, s_gnt_o, c_rvalid_o, s_rvalid_o, unexp_rsp_o});
        end

        // Secondary cap write stalls a cycle, then both beats, then FIFO-full response.
        @(negedge clk_i);
        {rst_i, c_req_i, s_req_i, c_is_cap_i, s_is_cap_i, data_gnt_i, data_rvalid_i} = 7'b0010100;
        #1;
        chk("sec req", 64'(data_req_o), 64'd1);
        chk("sec we", 64'(data_we_o), 64'd1);
        chk("sec be", 64'(data_be_o), 64'h3);
        chk("sec wdata", 64'(data_wdata_o), 64'h1_2345_6789);
        chk("sec is_cap", 64'(data_is_cap_o), 64'd1);
        chk("sec gnt stalled", 64'({c_gnt_o, s_gnt_o}), 64'd0);
        $display("seq stall: req=%b we=%b be=%h", data_req_o, data_we_o, data_be_o);

        @(negedge clk_i);
        c_req_i = 1'b1; data_gnt_i = 1'b1;
        #1;
        chk("cap beat1 gnt", 64'({c_gnt_o, s_gnt_o}), 64'b01);
        chk("cap beat1 addr", 64'(data_addr_o), 64'h200);
        $display("seq beat1: c_gnt=%b s_gnt=%b", c_gnt_o, s_gnt_o);

        @(negedge clk_i);
        #1;
        chk("cap beat2 gnt", 64'({c_gnt_o, s_gnt_o}), 64'b01);
        $display("seq beat2: c_gnt=%b s_gnt=%b", c_gnt_o, s_gnt_o);

        @(negedge clk_i);
        s_req_i = 1'b0; s_is_cap_i = 1'b0; data_rvalid_i = 1'b1;
        data_err_i = 1'b1; data_rdata_i = 33'h1_DEAD_BEEF;
        #1;
        chk("full req", 64'(data_req_o), 64'd0);
        chk("full c_gnt", 64'(c_gnt_o), 64'd0);
        chk("rsp1 rvalid", 64'({c_rvalid_o, s_rvalid_o}), 64'b01);
        chk("rsp1 err", 64'({c_err_o, s_err_o}), 64'b11);
        chk("rsp1 c_rdata", 64'(c_rdata_o), 64'h1_DEAD_BEEF);
        chk("rsp1 s_rdata", 64'(s_rdata_o), 64'h1_DEAD_BEEF);
        $display("seq rsp1: rv=%b%b err=%b rdata=%h", c_rvalid_o, s_rvalid_o, s_err_o, s_rdata_o);

        @(negedge clk_i);
        data_err_i = 1'b0; data_rdata_i = '0;
        #1;
        chk("core gnt", 64'(c_gnt_o), 64'd1);
        chk("core we", 64'(data_we_o), 64'd0);
        chk("core be", 64'(data_be_o), 64'hF);
        chk("core wdata", 64'(data_wdata_o), 64'hC0);
        chk("core is_cap", 64'(data_is_cap_o), 64'd0);
        chk("rsp2 rvalid", 64'({c_rvalid_o, s_rvalid_o}), 64'b01);
        $display("seq core: gnt=%b be=%h rv=%b%b", c_gnt_o, data_be_o, c_rvalid_o, s_rvalid_o);

        @(negedge clk_i);
        c_req_i = 1'b0; data_gnt_i = 1'b0;
        #1;
        chk("rsp3 rvalid", 64'({c_rvalid_o, s_rvalid_o, unexp_rsp_o}), 64'b100);
        $display("seq rsp3: rv=%b%b unexp=%b", c_rvalid_o, s_rvalid_o, unexp_rsp_o);

        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        #1;
        chk("idle unexp", 64'(unexp_rsp_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
